// File: rtl/uart_cmd_ctrl_if.sv
// Purpose: groups the received-byte stream, the measurement-core handshake and
//          the configuration/status outputs of uart_cmd_ctrl into one bundle.
// Ports:   master = byte source / measurement side, slave = the command sequencer.
interface uart_cmd_ctrl_if;
  logic        rx_valid;     // one-cycle strobe, rx_byte valid
  logic [7:0]  rx_byte;      // received byte
  logic        meas_busy;    // measurement core running
  logic        meas_start;   // one-cycle start pulse to measurement core
  logic [15:0] pulse_width;  // test pulse width in sys_clk cycles
  logic [2:0]  gain_sel;     // receive amplifier gain select
  logic        cmd_ok;       // one-cycle pulse, frame executed
  logic        cmd_err;      // one-cycle pulse, frame rejected
  logic [1:0]  err_code;     // cause of last error, held until next cmd_err

  modport master (
    output rx_valid, rx_byte, meas_busy,
    input  meas_start, pulse_width, gain_sel, cmd_ok, cmd_err, err_code
  );

  modport slave (
    input  rx_valid, rx_byte, meas_busy,
    output meas_start, pulse_width, gain_sel, cmd_ok, cmd_err, err_code
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Purpose: parses 55 AA CMD LEN DATA.. CHK frames from the UART byte stream and
//          updates measurement config / fires meas_start; one ok or err pulse per frame.
// Latency: results at N+2 after the CHK byte strobe, LEN/CHK errors at N+1.
// Backpressure: none; bytes arriving during the single EXEC cycle are dropped.
// Ports:   sys_clk, sys_rst_n (async, active-low), bus (uart_cmd_ctrl_if.slave).
module uart_cmd_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TIMEOUT_MS = 10,
  parameter int MAX_LEN    = 4,
  parameter int DEF_WIDTH  = 100
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_cmd_ctrl_if.slave bus
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [7:0] HDR1       = 8'h55;
  localparam logic [7:0] HDR2       = 8'hAA;
  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_WIDTH  = 8'h02;
  localparam logic [7:0] CMD_GAIN   = 8'h03;

  localparam logic [1:0] E_CHK   = 2'd0;
  localparam logic [1:0] E_ARG   = 2'd1;
  localparam logic [1:0] E_BUSY  = 2'd2;
  localparam logic [1:0] E_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_CMD, S_LEN, S_DATA, S_CHK, S_EXEC
  } state_t;

  state_t       state;
  logic [7:0]   cmd_reg;
  logic [7:0]   len_reg;
  logic [7:0]   chk_sum;
  logic [7:0]   byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]   data_buf [MAX_LEN];

  logic         meas_start_q;
  logic         cmd_ok_q;
  logic         cmd_err_q;
  logic [1:0]   err_code_q;
  logic [15:0]  pulse_width_q;
  logic [2:0]   gain_sel_q;

  logic [15:0]  width_arg;
  assign width_arg = {data_buf[0], data_buf[IW'(1 % MAX_LEN)]};

  assign bus.meas_start  = meas_start_q;
  assign bus.cmd_ok      = cmd_ok_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.pulse_width = pulse_width_q;
  assign bus.gain_sel    = gain_sel_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      cmd_reg       <= '0;
      len_reg       <= '0;
      chk_sum       <= '0;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      for (int i = 0; i < MAX_LEN; i++) data_buf[i] <= '0;
      meas_start_q  <= 1'b0;
      cmd_ok_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      err_code_q    <= E_CHK;
      pulse_width_q <= 16'(DEF_WIDTH);
      gain_sel_q    <= '0;
    end else begin
      // Pulses are single-cycle: cleared every cycle unless set below.
      meas_start_q <= 1'b0;
      cmd_ok_q     <= 1'b0;
      cmd_err_q    <= 1'b0;

      if (state == S_EXEC) begin
        // Any byte strobed in this cycle is intentionally ignored.
        state <= S_IDLE;
        case (cmd_reg)
          CMD_START: begin
            if (len_reg != 8'd0) begin
              cmd_err_q <= 1'b1; err_code_q <= E_ARG;
            end else if (bus.meas_busy) begin
              cmd_err_q <= 1'b1; err_code_q <= E_BUSY;
            end else begin
              meas_start_q <= 1'b1; cmd_ok_q <= 1'b1;
            end
          end
          CMD_WIDTH: begin
            if (len_reg != 8'd2 || width_arg == 16'd0) begin
              cmd_err_q <= 1'b1; err_code_q <= E_ARG;
            end else begin
              pulse_width_q <= width_arg; cmd_ok_q <= 1'b1;
            end
          end
          CMD_GAIN: begin
            if (len_reg != 8'd1 || data_buf[0] > 8'd7) begin
              cmd_err_q <= 1'b1; err_code_q <= E_ARG;
            end else begin
              gain_sel_q <= data_buf[0][2:0]; cmd_ok_q <= 1'b1;
            end
          end
          default: begin
            cmd_err_q <= 1'b1; err_code_q <= E_ARG;
          end
        endcase
      end else if (bus.rx_valid) begin
        tmo_cnt <= '0;
        case (state)
          S_IDLE: if (bus.rx_byte == HDR1) state <= S_HDR2;
          S_HDR2: begin
            // A repeated 0x55 may be the real start of a frame, so stay put.
            if (bus.rx_byte == HDR2)      state <= S_CMD;
            else if (bus.rx_byte != HDR1) state <= S_IDLE;
          end
          S_CMD: begin
            cmd_reg <= bus.rx_byte;
            chk_sum <= bus.rx_byte;
            state   <= S_LEN;
          end
          S_LEN: begin
            len_reg  <= bus.rx_byte;
            chk_sum  <= chk_sum + bus.rx_byte;
            byte_cnt <= '0;
            if (bus.rx_byte > 8'(MAX_LEN)) begin
              cmd_err_q  <= 1'b1;
              err_code_q <= E_ARG;
              state      <= S_IDLE;
            end else if (bus.rx_byte == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (byte_cnt < 8'(MAX_LEN)) data_buf[byte_cnt[IW-1:0]] <= bus.rx_byte;
            chk_sum  <= chk_sum + bus.rx_byte;
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == len_reg - 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (bus.rx_byte != chk_sum) begin
              cmd_err_q  <= 1'b1;
              err_code_q <= E_CHK;
              state      <= S_IDLE;
            end else begin
              state <= S_EXEC;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Inter-byte silence inside a frame (including right after 0x55).
        if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo_cnt    <= '0;
          cmd_err_q  <= 1'b1;
          err_code_q <= E_TMO;
          state      <= S_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule
